// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator for the Y86 memory stage: req/ack handshake,
// bounds and command checks, unresponsive-memory timeout, sticky error.
module dmem_access_ctrl #(
    parameter int MEM_WORDS = 8192,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_data,
    output logic        m_stall,
    output logic        m_done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [63:0]      ADDR_LIM = 64'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      valm_q, valm_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_range;
    logic legal_rw;

    assign in_range = (m_addr < ADDR_LIM);
    assign legal_rw = m_read ^ m_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valm_q  <= valm_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valm_d  = valm_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (!m_read && !m_write) begin
                        done_d = 1'b1;
                    end else if (!legal_rw || !in_range) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        addr_d  = m_addr;
                        wdata_d = m_data;
                        we_d    = m_write;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // an ack on the final timeout edge still completes normally
                if (mem_ack) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (!we_q) valm_d = mem_rdata;
                end else if (cnt_q == CNT_MAX) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALT: begin
                req_d = 1'b0;
                err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_stall    = (state_q == BUSY) ||
                        ((state_q == IDLE) && m_valid && legal_rw && in_range);
    assign m_done     = done_q;
    assign valM       = valm_q;
    assign dmem_error = err_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: store, load, bounds, illegal
// command, timeout, ack on the last edge, mid-access reset, back-to-back.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        m_valid;
    logic        m_read;
    logic        m_write;
    logic [63:0] m_addr;
    logic [63:0] m_data;
    logic        m_stall;
    logic        m_done;
    logic [63:0] valM;
    logic        dmem_error;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int checks;
    int failures;

    dmem_access_ctrl #(
        .MEM_WORDS(8192),
        .TIMEOUT  (16),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_valid   (m_valid),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_stall   (m_stall),
        .m_done    (m_done),
        .valM      (valM),
        .dmem_error(dmem_error),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        m_valid   = 1'b0;
        m_read    = 1'b0;
        m_write   = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req act=%0h exp=0", mem_req); end
        checks++; if (m_done !== 1'b0) begin failures++; $display("FAIL rst_done act=%0h exp=0", m_done); end
        checks++; if (dmem_error !== 1'b0) begin failures++; $display("FAIL rst_err act=%0h exp=0", dmem_error); end
        checks++; if (valM !== 64'h0) begin failures++; $display("FAIL rst_valM act=%0h exp=0", valM); end
        checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL rst_membus addr=%0h wdata=%0h we=%0h exp=0", mem_addr, mem_wdata, mem_we); end
    endtask

    task automatic test_store();
        int req_cyc;
        do_reset();
        m_valid = 1'b1; m_write = 1'b1; m_addr = 64'd5; m_data = 64'hDEAD;
        #1;
        checks++; if (m_stall !== 1'b1) begin failures++; $display("FAIL st_stall_pre act=%0h exp=1", m_stall); end
        edge1();
        idle_inputs();
        req_cyc = 0;
        if (mem_req === 1'b1) req_cyc++;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 64'd5 || mem_wdata !== 64'hDEAD) begin
            failures++; $display("FAIL st_bus we=%0h addr=%0h wdata=%0h exp=1/5/dead", mem_we, mem_addr, mem_wdata); end
        edge1();
        if (mem_req === 1'b1) req_cyc++;
        edge1();
        if (mem_req === 1'b1) req_cyc++;
        checks++; if (mem_addr !== 64'd5 || mem_wdata !== 64'hDEAD || mem_we !== 1'b1) begin
            failures++; $display("FAIL st_stable we=%0h addr=%0h wdata=%0h", mem_we, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        edge1();
        mem_ack = 1'b0;
        if (mem_req === 1'b1) req_cyc++;
        checks++; if (req_cyc !== 3) begin failures++; $display("FAIL st_req_cycles act=%0d exp=3", req_cyc); end
        checks++; if (m_done !== 1'b1) begin failures++; $display("FAIL st_done act=%0h exp=1", m_done); end
        checks++; if (valM !== 64'h0) begin failures++; $display("FAIL st_valM act=%0h exp=0", valM); end
        edge1();
        checks++; if (m_done !== 1'b0) begin failures++; $display("FAIL st_done_pulse act=%0h exp=0", m_done); end
    endtask

    task automatic test_load();
        do_reset();
        mem_ack = 1'b1; mem_rdata = 64'hDEAD;
        m_valid = 1'b1; m_read = 1'b1; m_addr = 64'd5;
        edge1();
        m_valid = 1'b0; m_read = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
            failures++; $display("FAIL ld_req req=%0h we=%0h exp=1/0", mem_req, mem_we); end
        checks++; if (m_stall !== 1'b1 || m_done !== 1'b0) begin
            failures++; $display("FAIL ld_busy stall=%0h done=%0h exp=1/0", m_stall, m_done); end
        edge1();
        checks++; if (m_done !== 1'b1 || valM !== 64'hDEAD) begin
            failures++; $display("FAIL ld_done done=%0h valM=%0h exp=1/dead", m_done, valM); end
        checks++; if (mem_req !== 1'b0 || m_stall !== 1'b0) begin
            failures++; $display("FAIL ld_release req=%0h stall=%0h exp=0/0", mem_req, m_stall); end
        mem_ack = 1'b0;
    endtask

    task automatic test_bounds();
        do_reset();
        m_valid = 1'b1; m_read = 1'b1; m_addr = 64'd8192;
        #1;
        checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL bd_stall act=%0h exp=0", m_stall); end
        edge1();
        checks++; if (dmem_error !== 1'b1 || m_done !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL bd_err err=%0h done=%0h req=%0h exp=1/1/0", dmem_error, m_done, mem_req); end
        m_addr = 64'd0; mem_ack = 1'b1;
        edge1();
        checks++; if (mem_req !== 1'b0 || m_done !== 1'b0 || m_stall !== 1'b0 || dmem_error !== 1'b1) begin
            failures++; $display("FAIL bd_halt req=%0h done=%0h stall=%0h err=%0h exp=0/0/0/1", mem_req, m_done, m_stall, dmem_error); end
        idle_inputs();
    endtask

    task automatic test_illegal();
        do_reset();
        m_valid = 1'b1; m_read = 1'b1; m_write = 1'b1; m_addr = 64'd3;
        edge1();
        idle_inputs();
        checks++; if (dmem_error !== 1'b1 || m_done !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL il_err err=%0h done=%0h req=%0h exp=1/1/0", dmem_error, m_done, mem_req); end
        m_valid = 1'b1; m_write = 1'b1; m_addr = 64'd3;
        edge1();
        checks++; if (mem_req !== 1'b0 || m_done !== 1'b0 || dmem_error !== 1'b1) begin
            failures++; $display("FAIL il_halt req=%0h done=%0h err=%0h exp=0/0/1", mem_req, m_done, dmem_error); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int req_cyc;
        int done_cnt;
        do_reset();
        m_valid = 1'b1; m_read = 1'b1; m_addr = 64'd7;
        edge1();
        idle_inputs();
        req_cyc = 0; done_cnt = 0;
        if (mem_req === 1'b1) req_cyc++;
        for (int i = 0; i < 20; i++) begin
            edge1();
            if (mem_req === 1'b1) req_cyc++;
            if (m_done === 1'b1) done_cnt++;
        end
        checks++; if (req_cyc !== 16) begin failures++; $display("FAIL to_req_cycles act=%0d exp=16", req_cyc); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL to_done_count act=%0d exp=1", done_cnt); end
        checks++; if (dmem_error !== 1'b1) begin failures++; $display("FAIL to_err act=%0h exp=1", dmem_error); end
    endtask

    task automatic test_ack_last_edge();
        do_reset();
        mem_rdata = 64'h1234;
        m_valid = 1'b1; m_read = 1'b1; m_addr = 64'd7;
        edge1();
        m_valid = 1'b0; m_read = 1'b0;
        repeat (15) edge1();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL al_req_held act=%0h exp=1", mem_req); end
        mem_ack = 1'b1;
        edge1();
        mem_ack = 1'b0;
        checks++; if (m_done !== 1'b1 || valM !== 64'h1234 || dmem_error !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL al_done done=%0h valM=%0h err=%0h req=%0h exp=1/1234/0/0", m_done, valM, dmem_error, mem_req); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_valid = 1'b1; m_read = 1'b1; m_addr = 64'd2;
        edge1();
        idle_inputs();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rm_busy act=%0h exp=1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || m_done !== 1'b0 || dmem_error !== 1'b0) begin
            failures++; $display("FAIL rm_async req=%0h done=%0h err=%0h exp=0/0/0", mem_req, m_done, dmem_error); end
        #1 rst_n = 1'b1;
        m_valid = 1'b1;
        edge1();
        m_valid = 1'b0;
        checks++; if (m_done !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL rm_noop done=%0h req=%0h exp=1/0", m_done, mem_req); end
        edge1();
        checks++; if (m_done !== 1'b0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL rm_after done=%0h req=%0h exp=0/0", m_done, mem_req); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_ack = 1'b1; mem_rdata = 64'h11;
        m_valid = 1'b1; m_read = 1'b1; m_addr = 64'd1;
        edge1();
        m_valid = 1'b0;
        edge1();
        checks++; if (m_done !== 1'b1 || valM !== 64'h11) begin
            failures++; $display("FAIL bb_first done=%0h valM=%0h exp=1/11", m_done, valM); end
        mem_rdata = 64'h22; m_valid = 1'b1; m_addr = 64'd8191;
        edge1();
        m_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'd8191) begin
            failures++; $display("FAIL bb_accept req=%0h addr=%0h exp=1/1fff", mem_req, mem_addr); end
        edge1();
        checks++; if (m_done !== 1'b1 || valM !== 64'h22 || dmem_error !== 1'b0) begin
            failures++; $display("FAIL bb_second done=%0h valM=%0h err=%0h exp=1/22/0", m_done, valM, dmem_error); end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        test_reset();
        test_store();
        test_load();
        test_bounds();
        test_illegal();
        test_timeout();
        test_ack_last_edge();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
